div_iter_unit: RTL

//  Parametrised iterative integer divider for the ALU M-extension path (DIV/DIVU/REM/REMU).

---
 rtl/div_iter_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/div_iter_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU); DIV_EARLY_OUT_EN skips ITER when |a|<|b|.
// Latency: XLEN/BPC+3 cycles normal, 2 for divide-by-zero/overflow, 3 for early-out.
// Backpressure: one op in flight, result held in DONE until out_ready; no accept outside IDLE.
module div_iter_unit #(
  parameter int XLEN  = 32,
  parameter int BPC   = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITERS = XLEN / BPC;
  localparam int CW    = $clog2(ITERS) + 1;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4) || (XLEN % BPC) != 0 || XLEN < 8) begin : g_bad_cfg
      $error("div_iter_unit: illegal XLEN/BPC combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q, dvd_q, dsr_q, quo_q, rem_q, result_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q, r_neg_q;

  logic             sgn, a_neg, b_neg, div_zero, ovf, special, early;
  logic [XLEN-1:0]  mag_a, mag_b, spec_res, q_fix, r_fix;
  logic [XLEN:0]    pr;
  logic [XLEN-1:0]  dv_nxt, q_nxt;

  assign in_ready  = (state_q == S_IDLE) && !flush && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign out_tag   = tag_q;

  // Operand analysis on the latched raw operands, used during PREP.
  assign sgn      = ~op_q[0];
  assign a_neg    = sgn & a_q[XLEN-1];
  assign b_neg    = sgn & b_q[XLEN-1];
  assign mag_a    = a_neg ? (~a_q + 1'b1) : a_q;
  assign mag_b    = b_neg ? (~b_q + 1'b1) : b_q;
  assign div_zero = (b_q == '0);
  assign ovf      = sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
  assign special  = div_zero | ovf;
  assign spec_res = div_zero ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);
`ifdef DIV_EARLY_OUT_EN
  assign early    = (mag_a < mag_b);
`else
  assign early    = 1'b0;
`endif
  assign q_fix    = q_neg_q ? (~quo_q + 1'b1) : quo_q;
  assign r_fix    = (r_neg_q && rem_q != '0) ? (~rem_q + 1'b1) : rem_q;

  // BPC restoring steps per cycle; partial remainder stays below |divisor|.
  always_comb begin
    pr     = {1'b0, rem_q};
    dv_nxt = dvd_q;
    q_nxt  = quo_q;
    for (int i = 0; i < BPC; i++) begin
      pr     = {pr[XLEN-1:0], dv_nxt[XLEN-1]};
      dv_nxt = {dv_nxt[XLEN-2:0], 1'b0};
      if (pr >= {1'b0, dsr_q}) begin
        pr    = pr - {1'b0, dsr_q};
        q_nxt = {q_nxt[XLEN-2:0], 1'b1};
      end else begin
        q_nxt = {q_nxt[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_nxt = S_PREP;
      S_PREP:  state_nxt = special ? S_DONE : (early ? S_FIXUP : S_ITER);
      S_ITER:  if (cnt_q == CW'(ITERS - 1)) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q  <= op;
            a_q   <= dividend;
            b_q   <= divisor;
            tag_q <= in_tag;
          end
        end
        S_PREP: begin
          dvd_q   <= mag_a;
          dsr_q   <= mag_b;
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          quo_q   <= '0;
          rem_q   <= early ? mag_a : '0;
          cnt_q   <= '0;
          if (special) result_q <= spec_res;
        end
        S_ITER: begin
          dvd_q <= dv_nxt;
          quo_q <= q_nxt;
          rem_q <= pr[XLEN-1:0];
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIXUP: result_q <= op_q[1] ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

endmodule
